// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU sequencer: opcode map, controller states and
// sizing constants used by the top level and the program memory.
package alu_seq_pkg;

  localparam int K_DEFAULT = 16;
  localparam int ADDR_W    = 4;
  localparam int LEN_W     = 5;
  localparam int OP_W      = 4;

  typedef logic [OP_W-1:0] opcode_t;

  localparam opcode_t OP_NOP  = 4'b0000;
  localparam opcode_t OP_CLR  = 4'b0001;
  localparam opcode_t OP_ADD  = 4'b0010;
  localparam opcode_t OP_SUB  = 4'b0011;
  localparam opcode_t OP_MUL  = 4'b0100;
  localparam opcode_t OP_DIV  = 4'b0101;
  localparam opcode_t OP_MOD  = 4'b0110;
  localparam opcode_t OP_NEG  = 4'b0111;
  localparam opcode_t OP_AND  = 4'b1000;
  localparam opcode_t OP_OR   = 4'b1001;
  localparam opcode_t OP_XOR  = 4'b1010;
  localparam opcode_t OP_NAND = 4'b1011;
  localparam opcode_t OP_NOR  = 4'b1100;
  localparam opcode_t OP_XNOR = 4'b1101;
  localparam opcode_t OP_SHL  = 4'b1110;
  localparam opcode_t OP_SHR  = 4'b1111;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RUN,
    DONE,
    FAULT
  } state_t;

  // Shift opcodes exist in the ALU map but are not legal in a stored program.
  function automatic logic is_illegal_op(input opcode_t op);
    return (op == OP_SHL) || (op == OP_SHR);
  endfunction

endpackage

// File: rtl/seq_prog_mem.sv
// Program store for the ALU sequencer: one synchronous write port and one
// combinational read port, each entry holding {opcode, operand A}.
module seq_prog_mem
  import alu_seq_pkg::*;
#(
  parameter int K     = K_DEFAULT,
  parameter int DEPTH = 16
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [OP_W-1:0]   i_wop,
  input  logic [K-1:0]      i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [OP_W-1:0]   o_rop,
  output logic [K-1:0]      o_rdata
);

  logic [OP_W+K-1:0] r_mem [DEPTH];

  // NOTE: the storage array has no reset; the program must survive rst, and a
  // resettable array would also stop it mapping onto plain RAM/register files.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= {i_wop, i_wdata};
    end
  end

  assign {o_rop, o_rdata} = r_mem[i_raddr];

endmodule

// File: rtl/alu_sequencer.sv
// Issues a stored program to an external accumulator ALU: one CLR cycle, then
// one instruction per cycle, collecting error flags and the final result.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int K     = K_DEFAULT,
  parameter int DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [OP_W-1:0]   prog_op,
  input  logic [K-1:0]      prog_data,
  input  logic [LEN_W-1:0]  prog_len,
  input  logic              halt_on_err,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              fault,
  output logic              illegal,
  output logic [ADDR_W-1:0] pc,
  output logic [1:0]        err_code,
  output logic [2*K-1:0]    result,
  output logic [OP_W-1:0]   alu_opcode,
  output logic [K-1:0]      alu_a,
  input  logic [2*K-1:0]    alu_c,
  input  logic [1:0]        alu_error
);

  state_t            r_state;
  state_t            w_next;
  logic [LEN_W-1:0]  r_len;
  logic              r_halt;
  logic [ADDR_W-1:0] r_pc;
  logic [1:0]        r_err;
  logic [2*K-1:0]    r_result;
  logic              r_illegal;

  logic [OP_W-1:0]   w_mem_op;
  logic [K-1:0]      w_mem_data;
  logic              w_idle_like;
  logic              w_mem_we;
  logic              w_illegal_op;
  logic              w_halt_now;
  logic              w_last;
  logic [LEN_W-1:0]  w_len_clamped;

  assign w_idle_like   = (r_state == IDLE) || (r_state == DONE) || (r_state == FAULT);
  assign w_mem_we      = prog_we && w_idle_like && !rst;
  assign w_illegal_op  = is_illegal_op(w_mem_op);
  assign w_halt_now    = r_halt && (alu_error != 2'b00);
  assign w_last        = ({1'b0, r_pc} == (r_len - LEN_W'(1)));
  assign w_len_clamped = (prog_len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : prog_len;

  seq_prog_mem #(
    .K     (K),
    .DEPTH (DEPTH)
  ) u_prog_mem (
    .clk     (clk),
    .i_we    (w_mem_we),
    .i_waddr (prog_addr),
    .i_wop   (prog_op),
    .i_wdata (prog_data),
    .i_raddr (r_pc),
    .o_rop   (w_mem_op),
    .o_rdata (w_mem_data)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE, DONE, FAULT: if (start) w_next = CLEAR;
      CLEAR:             w_next = (r_len == '0) ? DONE : RUN;
      RUN: begin
        if (w_illegal_op || w_halt_now) begin
          w_next = FAULT;
        end else if (w_last) begin
          w_next = DONE;
        end
      end
      default:           w_next = IDLE;
    endcase
  end

  // NOTE: every output gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    alu_opcode = OP_NOP;
    alu_a      = '0;
    busy       = 1'b0;
    done       = 1'b0;
    fault      = 1'b0;
    unique case (r_state)
      CLEAR: begin
        alu_opcode = OP_CLR;
        busy       = 1'b1;
      end
      RUN: begin
        alu_opcode = w_mem_op;
        alu_a      = w_mem_data;
        busy       = 1'b1;
      end
      DONE:    done  = 1'b1;
      FAULT:   fault = 1'b1;
      default: ;
    endcase
  end

  // Run context: latched on start, updated per issued instruction, frozen at run end.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_len     <= '0;
      r_halt    <= 1'b0;
      r_pc      <= '0;
      r_err     <= 2'b00;
      r_result  <= '0;
      r_illegal <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE, DONE, FAULT: begin
          if (start) begin
            r_len     <= w_len_clamped;
            r_halt    <= halt_on_err;
            r_pc      <= '0;
            r_err     <= 2'b00;
            r_illegal <= 1'b0;
          end
        end
        CLEAR: begin
          if (r_len == '0) r_result <= '0;
        end
        RUN: begin
          if (w_illegal_op) begin
            r_illegal <= 1'b1;
          end else begin
            r_err <= r_err | alu_error;
            if (w_halt_now || w_last) begin
              r_result <= alu_c;
            end else begin
              r_pc <= r_pc + ADDR_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign illegal  = r_illegal;
  assign pc       = r_pc;
  assign err_code = r_err;
  assign result   = r_result;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: models the accumulator ALU, runs a
// table of directed programs, hand-written corner sequences and random programs.
module tb_alu_sequencer;
  import alu_seq_pkg::*;

  localparam int K = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          prog_we;
  logic [3:0]    prog_addr;
  logic [3:0]    prog_op;
  logic [K-1:0]  prog_data;
  logic [4:0]    prog_len;
  logic          halt_on_err;
  logic          start;
  logic          busy, done, fault, illegal;
  logic [3:0]    pc;
  logic [1:0]    err_code;
  logic [2*K-1:0] result;
  logic [3:0]    alu_opcode;
  logic [K-1:0]  alu_a;
  logic [2*K-1:0] alu_c;
  logic [1:0]    alu_error;

  alu_sequencer #(.K(K), .DEPTH(16)) dut (
    .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_op(prog_op), .prog_data(prog_data), .prog_len(prog_len),
    .halt_on_err(halt_on_err), .start(start), .busy(busy), .done(done),
    .fault(fault), .illegal(illegal), .pc(pc), .err_code(err_code),
    .result(result), .alu_opcode(alu_opcode), .alu_a(alu_a),
    .alu_c(alu_c), .alu_error(alu_error)
  );

  always #5 clk = ~clk;

  // ---------------- accumulator ALU model (16-bit signed operands) ----------
  typedef struct packed {
    logic [31:0] c;
    logic [1:0]  err;   // {div-by-zero, overflow}
  } alu_res_t;

  function automatic logic [31:0] sext16(input int v);
    logic [15:0] w;
    w = v[15:0];
    return {{16{w[15]}}, w};
  endfunction

  function automatic alu_res_t alu_eval(input logic [3:0] op, input logic [31:0] acc,
                                        input logic [15:0] a);
    alu_res_t r;
    int x, y, t;
    x = int'($signed(acc[15:0]));
    y = int'($signed(a));
    r.c = acc;
    r.err = 2'b00;
    case (op)
      OP_CLR: r.c = '0;
      OP_ADD: begin t = x + y; r.c = sext16(t); r.err[0] = (t > 32767) || (t < -32768); end
      OP_SUB: begin t = x - y; r.c = sext16(t); r.err[0] = (t > 32767) || (t < -32768); end
      OP_MUL: begin t = x * y; r.c = t; end
      OP_DIV: begin
        if (y == 0) r.err[1] = 1'b1;
        else begin t = x / y; r.c = t; r.err[0] = (t > 32767); end
      end
      OP_MOD: begin
        if (y == 0) r.err[1] = 1'b1;
        else begin t = x % y; r.c = t; end
      end
      OP_NEG:  begin t = -x; r.c = sext16(t); r.err[0] = (x == -32768); end
      OP_AND:  r.c = {16'h0, acc[15:0] & a};
      OP_OR:   r.c = {16'h0, acc[15:0] | a};
      OP_XOR:  r.c = {16'h0, acc[15:0] ^ a};
      OP_NAND: r.c = {16'h0, ~(acc[15:0] & a)};
      OP_NOR:  r.c = {16'h0, ~(acc[15:0] | a)};
      OP_XNOR: r.c = {16'h0, ~(acc[15:0] ^ a)};
      OP_SHL:  r.c = acc << 1;
      OP_SHR:  r.c = acc >> 1;
      default: ;
    endcase
    return r;
  endfunction

  logic [31:0] tb_acc = '0;
  alu_res_t    alu_now;
  always_comb alu_now = alu_eval(alu_opcode, tb_acc, alu_a);
  assign alu_c     = alu_now.c;
  assign alu_error = alu_now.err;
  always @(posedge clk) tb_acc <= alu_now.c;

  // ---------------- scoreboard / reference model ----------------------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct packed {
    bit          done;
    bit          fault;
    bit          illegal;
    logic [3:0]  pc;
    logic [1:0]  err;
    logic [31:0] result;
    int          cycles;   // negedges after the start edge until done/fault shows
  } outcome_t;

  logic [3:0]  sh_op  [16];   // what the program memory should hold
  logic [15:0] sh_dat [16];
  logic [31:0] exp_prev = '0; // result expected to be held from the previous run

  // Whole-run model: walk the program as a list, no notion of cycles or states.
  function automatic outcome_t model_run(input int len_in, input bit halt, input logic [31:0] prev);
    outcome_t o;
    alu_res_t r;
    logic [31:0] acc;
    int n;
    n = (len_in > 16) ? 16 : len_in;
    o = '0;
    o.result = prev;
    if (n == 0) begin
      o.done = 1'b1; o.result = '0; o.cycles = 2;
      return o;
    end
    acc = '0;
    for (int i = 0; i < n; i++) begin
      o.pc = 4'(i);
      o.cycles = 3 + i;
      if (sh_op[i] == OP_SHL || sh_op[i] == OP_SHR) begin
        o.fault = 1'b1; o.illegal = 1'b1;
        return o;
      end
      r = alu_eval(sh_op[i], acc, sh_dat[i]);
      o.err = o.err | r.err;
      if (halt && r.err != 2'b00) begin
        o.fault = 1'b1; o.result = r.c;
        return o;
      end
      acc = r.c;
    end
    o.done = 1'b1;
    o.result = acc;
    return o;
  endfunction

  task automatic write_entry(input int addr, input logic [3:0] op, input logic [15:0] d);
    prog_we = 1'b1; prog_addr = 4'(addr); prog_op = op; prog_data = d;
    @(negedge clk);
    prog_we = 1'b0;
    sh_op[addr] = op;
    sh_dat[addr] = d;
  endtask

  // Called at a negedge; pulses start and waits (bounded) for the run to end.
  task automatic run_check(input string nm, input int len, input bit halt, input outcome_t e);
    int cyc;
    prog_len = 5'(len); halt_on_err = halt; start = 1'b1;
    @(negedge clk);
    start = 1'b0; prog_we = 1'b0; cyc = 1;
    while (!(done || fault) && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check({nm, ".cycles"},  64'(cyc),      64'(e.cycles));
    check({nm, ".done"},    64'(done),     64'(e.done));
    check({nm, ".fault"},   64'(fault),    64'(e.fault));
    check({nm, ".illegal"}, 64'(illegal),  64'(e.illegal));
    check({nm, ".pc"},      64'(pc),       64'(e.pc));
    check({nm, ".err"},     64'(err_code), 64'(e.err));
    check({nm, ".result"},  64'(result),   64'(e.result));
    exp_prev = e.result;
  endtask

  task automatic run_model(input string nm, input int len, input bit halt);
    run_check(nm, len, halt, model_run(len, halt, exp_prev));
  endtask

  // ---------------- directed vector table ----------------------------------
  typedef struct {
    string       name;
    logic [3:0]  op  [4];
    logic [15:0] dat [4];
    int          len;
    bit          halt;
    outcome_t    exp;
  } vec_t;

  function automatic vec_t mk_vec(input string nm,
      input logic [3:0] o0, input logic [3:0] o1, input logic [3:0] o2, input logic [3:0] o3,
      input logic [15:0] d0, input logic [15:0] d1, input logic [15:0] d2, input logic [15:0] d3,
      input int len, input bit halt, input bit e_done, input bit e_fault, input bit e_ill,
      input logic [3:0] e_pc, input logic [1:0] e_err, input logic [31:0] e_res);
    vec_t v;
    v.name = nm;
    v.op[0] = o0; v.op[1] = o1; v.op[2] = o2; v.op[3] = o3;
    v.dat[0] = d0; v.dat[1] = d1; v.dat[2] = d2; v.dat[3] = d3;
    v.len = len; v.halt = halt;
    v.exp = '0;
    v.exp.done = e_done; v.exp.fault = e_fault; v.exp.illegal = e_ill;
    v.exp.pc = e_pc; v.exp.err = e_err; v.exp.result = e_res;
    v.exp.cycles = e_done ? 2 + len : 3 + int'(e_pc);
    return v;
  endfunction

  vec_t vecs [6];

  initial begin
    logic [3:0] seq_ops [5];
    logic [3:0] rop;
    logic [15:0] rdat;

    vecs[0] = mk_vec("mul_chain", OP_ADD, OP_MUL, OP_MUL, OP_DIV, 16'd20, 16'd20, 16'd10, 16'd2,
                     4, 1'b0, 1'b1, 1'b0, 1'b0, 4'd3, 2'b00, 32'd2000);
    vecs[1] = mk_vec("add_mul_div", OP_ADD, OP_ADD, OP_MUL, OP_DIV, 16'd30, 16'd50, 16'd26, 16'd2,
                     4, 1'b0, 1'b1, 1'b0, 1'b0, 4'd3, 2'b00, 32'd1040);
    vecs[2] = mk_vec("div0_halt", OP_ADD, OP_DIV, OP_NOP, OP_NOP, 16'hC44A, 16'd0, 16'd0, 16'd0,
                     2, 1'b1, 1'b0, 1'b1, 1'b0, 4'd1, 2'b10, 32'hFFFFC44A);
    vecs[3] = mk_vec("ovf_nohalt", OP_ADD, OP_ADD, OP_NOP, OP_NOP, 16'h7FFF, 16'h7FFF, 16'd0, 16'd0,
                     2, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 2'b01, 32'hFFFFFFFE);
    vecs[4] = mk_vec("len_zero", OP_ADD, OP_ADD, OP_ADD, OP_ADD, 16'd1, 16'd1, 16'd1, 16'd1,
                     0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 2'b00, 32'd0);
    vecs[5] = mk_vec("illegal_shl", OP_ADD, OP_SHL, OP_NOP, OP_NOP, 16'd5, 16'd0, 16'd0, 16'd0,
                     2, 1'b0, 1'b0, 1'b1, 1'b1, 4'd1, 2'b00, 32'd0);

    rst = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_op = '0; prog_data = '0;
    prog_len = '0; halt_on_err = 1'b0; start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    check("rst.busy",    64'(busy),       64'd0);
    check("rst.done",    64'(done),       64'd0);
    check("rst.fault",   64'(fault),      64'd0);
    check("rst.illegal", 64'(illegal),    64'd0);
    check("rst.pc",      64'(pc),         64'd0);
    check("rst.err",     64'(err_code),   64'd0);
    check("rst.result",  64'(result),     64'd0);
    check("rst.opcode",  64'(alu_opcode), 64'(OP_NOP));

    for (int v = 0; v < 6; v++) begin
      for (int j = 0; j < 4; j++) write_entry(j, vecs[v].op[j], vecs[v].dat[j]);
      run_check(vecs[v].name, vecs[v].len, vecs[v].halt, vecs[v].exp);
    end

    // Back-to-back runs without rst: CLR is issued first again, same result.
    for (int j = 0; j < 4; j++) write_entry(j, vecs[1].op[j], vecs[1].dat[j]);
    run_model("rerun_a", 4, 1'b0);
    seq_ops[0] = OP_CLR; seq_ops[1] = OP_ADD; seq_ops[2] = OP_ADD;
    seq_ops[3] = OP_MUL; seq_ops[4] = OP_DIV;
    prog_len = 5'd4; halt_on_err = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      check($sformatf("rerun.op%0d", k),   64'(alu_opcode), 64'(seq_ops[k-1]));
      check($sformatf("rerun.busy%0d", k), 64'(busy),       64'd1);
      check($sformatf("rerun.done%0d", k), 64'(done),       64'd0);
      @(negedge clk);
    end
    check("rerun.done",   64'(done),       64'd1);
    check("rerun.result", 64'(result),     64'd1040);
    check("rerun.opnop",  64'(alu_opcode), 64'(OP_NOP));
    repeat (3) @(negedge clk);
    check("hold.result", 64'(result),   64'd1040);
    check("hold.pc",     64'(pc),       64'd3);
    check("hold.err",    64'(err_code), 64'd0);
    check("hold.done",   64'(done),     64'd1);

    // Write and start while busy are dropped; rst mid-run aborts to IDLE.
    prog_len = 5'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    prog_we = 1'b1; prog_addr = 4'd0; prog_op = OP_SUB; prog_data = 16'd999; start = 1'b1;
    @(negedge clk);
    prog_we = 1'b0; start = 1'b0;
    check("busy_start.op",   64'(alu_opcode), 64'(OP_ADD));
    check("busy_start.pc",   64'(pc),         64'd1);
    check("busy_start.busy", 64'(busy),       64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst.busy",    64'(busy),       64'd0);
    check("midrst.done",    64'(done),       64'd0);
    check("midrst.fault",   64'(fault),      64'd0);
    check("midrst.illegal", 64'(illegal),    64'd0);
    check("midrst.pc",      64'(pc),         64'd0);
    check("midrst.err",     64'(err_code),   64'd0);
    check("midrst.result",  64'(result),     64'd0);
    check("midrst.opcode",  64'(alu_opcode), 64'(OP_NOP));
    exp_prev = '0;
    // rst beats a simultaneous start and write
    rst = 1'b1; start = 1'b1; prog_we = 1'b1; prog_addr = 4'd1; prog_op = OP_SUB; prog_data = 16'd7;
    @(negedge clk);
    rst = 1'b0; start = 1'b0; prog_we = 1'b0;
    check("rst_start.busy",   64'(busy),       64'd0);
    check("rst_start.opcode", 64'(alu_opcode), 64'(OP_NOP));
    run_model("mem_kept", 4, 1'b0);
    check("mem_kept.value", 64'(result), 64'd1040);

    // A write in the same cycle as start is used by that run.
    prog_we = 1'b1; prog_addr = 4'd3; prog_op = OP_DIV; prog_data = 16'd4;
    sh_op[3] = OP_DIV; sh_dat[3] = 16'd4;
    run_model("wr_start", 4, 1'b0);
    check("wr_start.value", 64'(result), 64'd520);

    // Random programs, lengths up to 20 (clamped to 16), random halt policy.
    for (int it = 0; it < 40; it++) begin
      for (int j = 0; j < 16; j++) begin
        rop = 4'($urandom_range(0, 15));
        if (rop >= 4'd14 && $urandom_range(0, 7) != 0) rop = rop - 4'd12;
        rdat = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom);
        write_entry(j, rop, rdat);
      end
      run_model($sformatf("rnd%0d", it), int'($urandom_range(0, 20)), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
